// File: rtl/auto_load_seq.sv
// Auto-load sequencer: walks FIRST_ADDR..LAST_ADDR issuing one EXECUTE read per word.
// Supports abort after the in-flight word, plus a per-word BUSY timeout with bounded retry.
module auto_load_seq #(
    parameter int                ADDR_W     = 6,
    parameter logic [ADDR_W-1:0] FIRST_ADDR = '0,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(33),
    parameter int                GUARD      = 2,
    parameter int                TMO_W      = 10,
    parameter int                MAX_RETRY  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              busy_i,
    input  logic              al_done_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              al_ena_o,
    output logic              clr_al_done_o,
    output logic              execute_o,
    output logic              inc_o,
    output logic              completed_o,
    output logic              aborted_o,
    output logic              timed_out_o,
    output logic [1:0]        retries_o,
    output logic [3:0]        al_state_o
);

    localparam int                RTY_W       = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RTY_W-1:0]  MAX_RETRY_C = RTY_W'(MAX_RETRY);
    localparam logic [TMO_W-1:0]  GUARD_C     = TMO_W'(GUARD);
    localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'((2 ** TMO_W) - 2);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INIT  = 4'd1,
        S_ISSUE = 4'd2,
        S_WAIT  = 4'd3,
        S_NEXT  = 4'd4,
        S_DONE  = 4'd5,
        S_ABORT = 4'd6,
        S_ERROR = 4'd7
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [RTY_W-1:0]  retry_q, retry_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [1:0]        retries_d;
    logic              past_guard;
    logic              tmo_expired;

    logic              al_ena_q, clr_q, exec_q, inc_q;
    logic              completed_q, aborted_q, timed_out_q;
    logic [1:0]        retries_q;
    logic [3:0]        al_state_q;

    // The last WAIT cycle always ends the guard, so a short timeout can never be masked.
    assign tmo_expired = (tmo_q == TMO_LAST);
    assign past_guard  = (tmo_q >= GUARD_C) || tmo_expired;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d = state_q;
        addr_d  = addr_q;
        retry_d = retry_q;
        tmo_d   = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_INIT;
                    addr_d  = FIRST_ADDR;
                    retry_d = '0;
                end
            end
            S_INIT:  state_d = S_ISSUE;
            S_ISSUE: begin
                state_d = S_WAIT;
                tmo_d   = '0;
            end
            S_WAIT: begin
                if (past_guard && !busy_i) begin
                    if (al_done_i) begin
                        state_d = S_ABORT;
                    end else if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_NEXT;
                        addr_d  = addr_q + ADDR_W'(1);
                        retry_d = '0;
                    end
                end else if (tmo_expired) begin
                    if (retry_q < MAX_RETRY_C) begin
                        state_d = S_ISSUE;
                        retry_d = retry_q + RTY_W'(1);
                    end else begin
                        state_d = S_ERROR;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_NEXT:  state_d = S_ISSUE;
            S_DONE, S_ABORT, S_ERROR: begin
                if (!start_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        retries_d = (32'(retry_d) > 3) ? 2'd3 : 2'(retry_d);
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= FIRST_ADDR;
            retry_q     <= '0;
            tmo_q       <= '0;
            al_ena_q    <= 1'b0;
            clr_q       <= 1'b0;
            exec_q      <= 1'b0;
            inc_q       <= 1'b0;
            completed_q <= 1'b0;
            aborted_q   <= 1'b0;
            timed_out_q <= 1'b0;
            retries_q   <= 2'd0;
            al_state_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            al_ena_q    <= (state_d != S_IDLE);
            clr_q       <= (state_d == S_INIT);
            exec_q      <= (state_d == S_ISSUE);
            inc_q       <= (state_d == S_NEXT);
            completed_q <= (state_d == S_DONE);
            aborted_q   <= (state_d == S_ABORT);
            timed_out_q <= (state_d == S_ERROR);
            retries_q   <= retries_d;
            al_state_q  <= state_d;
        end
    end

    assign addr_o        = addr_q;
    assign al_ena_o      = al_ena_q;
    assign clr_al_done_o = clr_q;
    assign execute_o     = exec_q;
    assign inc_o         = inc_q;
    assign completed_o   = completed_q;
    assign aborted_o     = aborted_q;
    assign timed_out_o   = timed_out_q;
    assign retries_o     = retries_q;
    assign al_state_o    = al_state_q;

endmodule

// File: tb/tb_auto_load_seq.sv
// Bench for auto_load_seq: a BUSY responder emulates the read engine; each run is
// predicted word-by-word from the load rules and compared against the observed strobes.
module tb_auto_load_seq;

    localparam int ADDR_W    = 6;
    localparam int FIRST     = 0;
    localparam int LAST      = 33;
    localparam int GUARD     = 2;
    localparam int TMO_W     = 10;
    localparam int MAX_RETRY = 2;
    localparam int TMO_CYC   = (1 << TMO_W) - 1;
    localparam int RUN_BOUND = 20000;

    logic              clk_i     = 1'b0;
    logic              rst_i     = 1'b1;
    logic              start_i   = 1'b0;
    logic              busy_i    = 1'b0;
    logic              al_done_i = 1'b0;
    logic [ADDR_W-1:0] addr_o;
    logic              al_ena_o, clr_al_done_o, execute_o, inc_o;
    logic              completed_o, aborted_o, timed_out_o;
    logic [1:0]        retries_o;
    logic [3:0]        al_state_o;

    auto_load_seq #(
        .ADDR_W    (ADDR_W),
        .FIRST_ADDR(ADDR_W'(FIRST)),
        .LAST_ADDR (ADDR_W'(LAST)),
        .GUARD     (GUARD),
        .TMO_W     (TMO_W),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .busy_i       (busy_i),
        .al_done_i    (al_done_i),
        .addr_o       (addr_o),
        .al_ena_o     (al_ena_o),
        .clr_al_done_o(clr_al_done_o),
        .execute_o    (execute_o),
        .inc_o        (inc_o),
        .completed_o  (completed_o),
        .aborted_o    (aborted_o),
        .timed_out_o  (timed_out_o),
        .retries_o    (retries_o),
        .al_state_o   (al_state_o)
    );

    always #5 clk_i = ~clk_i;

    int     tests_run    = 0;
    int     tests_failed = 0;

    // Engine behaviour per address: BUSY length, and how many attempts hang with BUSY stuck.
    int     busy_len [64];
    int     stuck    [64];
    int     abort_addr = -1;
    int     idle_req   = 0;

    // Observations, owned by the responder and cleared at each run start.
    int     tries    [64];
    int     n_exec   = 0;
    int     n_inc    = 0;
    int     exec_addr_q[$];
    longint exec_cyc_q[$];
    longint cyc = 0;

    initial begin : responder
        int rem;
        int seen;
        int a;
        rem  = 0;
        seen = 0;
        foreach (tries[i]) tries[i] = 0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (seen != idle_req) begin
                seen      = idle_req;
                busy_i    = 1'b0;
                al_done_i = 1'b0;
                rem       = 0;
            end
            if (clr_al_done_o) begin
                al_done_i = 1'b0;
                n_exec    = 0;
                n_inc     = 0;
                exec_addr_q.delete();
                exec_cyc_q.delete();
                foreach (tries[i]) tries[i] = 0;
            end
            if (inc_o) n_inc++;
            if (execute_o) begin
                a = int'(addr_o);
                n_exec++;
                exec_addr_q.push_back(a);
                exec_cyc_q.push_back(cyc);
                busy_i = 1'b1;
                rem    = (tries[a] < stuck[a]) ? -1 : busy_len[a];
                tries[a]++;
                if (a == abort_addr) al_done_i = 1'b1;
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) busy_i = 1'b0;
            end
        end
    end

    task automatic set_cfg(input int len, input int abort_a);
        foreach (busy_len[i]) begin
            busy_len[i] = len;
            stuck[i]    = 0;
        end
        abort_addr = abort_a;
        idle_req++;
        @(negedge clk_i);
    endtask

    // Runs one load with START held, predicts the outcome from the per-word rules, then releases START.
    task automatic do_run(input string name, input int probe_addr);
        int kind, ex, inc, eaddr, erty, waited, ex_hold, bad;
        int exp_q[$];
        bit probed;
        logic [2:0] flags_exp;

        ex = 0; inc = 0; kind = 0; eaddr = FIRST; erty = 0;
        for (int a = FIRST; a <= LAST; a++) begin
            int att;
            att = (stuck[a] > MAX_RETRY) ? MAX_RETRY + 1 : stuck[a] + 1;
            for (int k = 0; k < att; k++) exp_q.push_back(a);
            ex   += att;
            eaddr = a;
            if (stuck[a] > MAX_RETRY) begin
                kind = 7; erty = MAX_RETRY; break;
            end
            erty = stuck[a];
            if (a == abort_addr) begin kind = 6; break; end
            if (a == LAST)       begin kind = 5; break; end
            inc++;
        end
        if (erty > 3) erty = 3;
        flags_exp = (kind == 5) ? 3'b100 : (kind == 6) ? 3'b010 : 3'b001;

        start_i = 1'b1;
        waited  = 0;
        probed  = 1'b0;
        while (!(al_state_o inside {4'd5, 4'd6, 4'd7}) && waited < RUN_BOUND) begin
            @(negedge clk_i);
            waited++;
            if (probe_addr >= 0 && !probed && int'(addr_o) == probe_addr && al_state_o == 4'd4) begin
                probed = 1'b1;
                tests_run++;
                if (retries_o !== 2'd0 || inc_o !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s probe_addr%0d: retries=%0d inc=%0d, want retries=0 inc=1",
                             name, probe_addr, retries_o, inc_o);
                end
            end
        end

        tests_run++;
        if (waited >= RUN_BOUND) begin
            tests_failed++;
            $display("FAIL %s hold_reached: no hold state after %0d cycles (state=%0d)", name, waited, al_state_o);
        end else begin
            tests_run += 6;
            if (al_state_o !== 4'(kind)) begin
                tests_failed++;
                $display("FAIL %s state: got %0d want %0d", name, al_state_o, kind);
            end
            if ({completed_o, aborted_o, timed_out_o} !== flags_exp) begin
                tests_failed++;
                $display("FAIL %s flags(cmp,abt,tmo): got %b want %b", name,
                         {completed_o, aborted_o, timed_out_o}, flags_exp);
            end
            if (addr_o !== ADDR_W'(eaddr)) begin
                tests_failed++;
                $display("FAIL %s addr: got %0d want %0d", name, addr_o, eaddr);
            end
            if (retries_o !== 2'(erty)) begin
                tests_failed++;
                $display("FAIL %s retries: got %0d want %0d", name, retries_o, erty);
            end
            if (n_exec != ex || n_inc != inc) begin
                tests_failed++;
                $display("FAIL %s counts: exec=%0d inc=%0d, want exec=%0d inc=%0d", name, n_exec, n_inc, ex, inc);
            end
            bad = (exec_addr_q.size() != exp_q.size()) ? 1 : 0;
            if (bad == 0)
                foreach (exp_q[i]) if (exec_addr_q[i] != exp_q[i]) bad++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL %s exec_addr_seq: %0d issues seen, %0d mismatching, want %0d issues",
                         name, exec_addr_q.size(), bad, exp_q.size());
            end
            if (exec_addr_q.size() == exp_q.size()) begin
                for (int i = 1; i < exec_addr_q.size(); i++) begin
                    if (exec_addr_q[i] == exec_addr_q[i-1]) begin
                        tests_run++;
                        if (exec_cyc_q[i] - exec_cyc_q[i-1] != longint'(TMO_CYC + 1)) begin
                            tests_failed++;
                            $display("FAIL %s retry_gap@%0d: got %0d cycles want %0d", name,
                                     exec_addr_q[i], exec_cyc_q[i] - exec_cyc_q[i-1], TMO_CYC + 1);
                        end
                    end
                end
            end

            ex_hold = n_exec;
            repeat (4) @(negedge clk_i);
            tests_run++;
            if (al_state_o !== 4'(kind) || n_exec != ex_hold || al_ena_o !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s hold_with_start: state=%0d exec=%0d ena=%0d, want state=%0d exec=%0d ena=1",
                         name, al_state_o, n_exec, al_ena_o, kind, ex_hold);
            end
        end

        start_i = 1'b0;
        @(negedge clk_i);
        tests_run++;
        if (al_state_o !== 4'd0 || al_ena_o !== 1'b0 || {completed_o, aborted_o, timed_out_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL %s release: state=%0d ena=%0d flags=%b, want 0/0/000", name,
                     al_state_o, al_ena_o, {completed_o, aborted_o, timed_out_o});
        end
        if (waited >= RUN_BOUND) begin
            rst_i = 1'b1;
            @(negedge clk_i);
            rst_i = 1'b0;
        end
        idle_req++;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        tests_run += 2;
        if (addr_o !== ADDR_W'(FIRST) || al_state_o !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_state: addr=%0d state=%0d, want %0d/0", addr_o, al_state_o, FIRST);
        end
        if ({al_ena_o, clr_al_done_o, execute_o, inc_o, completed_o, aborted_o, timed_out_o, retries_o} !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b want 0", {al_ena_o, clr_al_done_o, execute_o, inc_o,
                     completed_o, aborted_o, timed_out_o, retries_o});
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        tests_run++;
        if (al_state_o !== 4'd0 || al_ena_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_start: state=%0d ena=%0d, want 0/0", al_state_o, al_ena_o);
        end
    endtask

    task automatic test_start_latency();
        set_cfg(3, -1);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        tests_run++;
        if (clr_al_done_o !== 1'b1 || execute_o !== 1'b0 || al_state_o !== 4'd1 || al_ena_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_init: clr=%0d exec=%0d state=%0d ena=%0d, want 1/0/1/1",
                     clr_al_done_o, execute_o, al_state_o, al_ena_o);
        end
        @(posedge clk_i); #1;
        tests_run++;
        if (execute_o !== 1'b1 || clr_al_done_o !== 1'b0 || al_state_o !== 4'd2 || addr_o !== ADDR_W'(FIRST)) begin
            tests_failed++;
            $display("FAIL latency_issue: exec=%0d clr=%0d state=%0d addr=%0d, want 1/0/2/%0d",
                     execute_o, clr_al_done_o, al_state_o, addr_o, FIRST);
        end
        @(negedge clk_i);
        start_i = 1'b0;
        rst_i   = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_req++;
        @(negedge clk_i);
    endtask

    task automatic test_full_run();
        set_cfg(3, -1);
        do_run("full_run", -1);
    endtask

    task automatic test_abort();
        set_cfg(3, 5);
        do_run("abort_at5", -1);
    endtask

    task automatic test_timeout();
        set_cfg(3, -1);
        stuck[7] = 99;
        do_run("timeout_at7", -1);
    endtask

    task automatic test_retry_recover();
        set_cfg(3, -1);
        stuck[2] = 1;
        do_run("retry_recover", 3);
    endtask

    task automatic test_reset_midrun();
        int waited;
        set_cfg(3, -1);
        start_i = 1'b1;
        waited  = 0;
        while (int'(addr_o) != 10 && waited < 2000) begin
            @(negedge clk_i);
            waited++;
        end
        tests_run++;
        if (waited >= 2000) begin
            tests_failed++;
            $display("FAIL midrun_reach_addr10: addr=%0d after %0d cycles, want 10", addr_o, waited);
        end
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        tests_run++;
        if (al_state_o !== 4'd0 || addr_o !== ADDR_W'(FIRST) ||
            {al_ena_o, clr_al_done_o, execute_o, inc_o, completed_o, aborted_o, timed_out_o, retries_o} !== 9'd0) begin
            tests_failed++;
            $display("FAIL midrun_reset: state=%0d addr=%0d outs=%b, want 0/%0d/0", al_state_o, addr_o,
                     {al_ena_o, clr_al_done_o, execute_o, inc_o, completed_o, aborted_o, timed_out_o, retries_o}, FIRST);
        end
        @(negedge clk_i);
        tests_run++;
        if (clr_al_done_o !== 1'b1 || al_state_o !== 4'd1) begin
            tests_failed++;
            $display("FAIL midrun_restart: clr=%0d state=%0d, want 1/1", clr_al_done_o, al_state_o);
        end
        do_run("midrun_rerun", -1);
    endtask

    task automatic test_abort_last();
        set_cfg(3, LAST);
        do_run("abort_last", -1);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            foreach (busy_len[i]) begin
                busy_len[i] = int'($urandom_range(1, 12));
                stuck[i]    = 0;
            end
            if ($urandom_range(0, 1) == 1)
                stuck[int'($urandom_range(FIRST, LAST))] = int'($urandom_range(1, 3));
            abort_addr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(FIRST, LAST)) : -1;
            idle_req++;
            @(negedge clk_i);
            do_run("random", -1);
        end
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_full_run();
        test_abort();
        test_timeout();
        test_retry_recover();
        test_reset_midrun();
        test_abort_last();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
